// File: rtl/mha_pkg.sv
// Shared definitions for the weight-stationary MAC array sequencer:
// FSM encoding, accumulator width and weight-control polarity.
package mha_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // MAC control value that shifts weights down one row.
  localparam logic READ_WEIGHT_DATA = 1'b1;

  // Accumulator width of a MAC column: full product plus growth over the rows.
  function automatic int ACC_W(input int bit_width, input int rows);
    return 2 * bit_width + rows - 1;
  endfunction

endpackage

// File: rtl/systolic_array_ctrl_if.sv
// Bundle of job control, weight/feature streams and array-facing signals
// shared by the sequencer and its environment.
interface systolic_array_ctrl_if
  import mha_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int BIT_WIDTH = 8,
  parameter int CNT_W     = 8
);
  localparam int ACC_WIDTH = ACC_W(BIT_WIDTH, ROWS);

  logic                          start;
  logic [CNT_W-1:0]              cfg_num_vec;
  logic                          busy;
  logic                          done;
  logic                          wt_valid;
  logic                          wt_ready;
  logic [COLS*BIT_WIDTH-1:0]     wt_data;
  logic                          in_valid;
  logic                          in_ready;
  logic [ROWS*BIT_WIDTH-1:0]     in_data;
  logic                          arr_control;
  logic [COLS*BIT_WIDTH-1:0]     arr_weight;
  logic [ROWS*BIT_WIDTH-1:0]     arr_data;
  logic [COLS*ACC_WIDTH-1:0]     arr_acc_top;
  logic [COLS-1:0]               out_col_valid;

  modport master (
    output start, cfg_num_vec, wt_valid, wt_data, in_valid, in_data,
    input  busy, done, wt_ready, in_ready, arr_control, arr_weight,
           arr_data, arr_acc_top, out_col_valid
  );

  modport slave (
    input  start, cfg_num_vec, wt_valid, wt_data, in_valid, in_data,
    output busy, done, wt_ready, in_ready, arr_control, arr_weight,
           arr_data, arr_acc_top, out_col_valid
  );
endinterface

// File: rtl/systolic_array_ctrl_skew_line.sv
// Fixed-depth delay line for one array row, with a flag telling the
// sequencer whether any stage still holds a nonzero element.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             nonzero
);
  logic [WIDTH-1:0] stage_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign q = stage_reg[DEPTH-1];

  always_comb begin
    nonzero = 1'b0;
    for (int i = 0; i < DEPTH; i++) nonzero = nonzero | (|stage_reg[i]);
  end
endmodule

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for a weight-stationary MAC array: loads ROWS weight rows,
// streams skewed feature vectors, drains, and flags valid bottom-row results.
module systolic_array_ctrl
  import mha_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int BIT_WIDTH = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  systolic_array_ctrl_if.slave bus
);
  localparam int WCNT_W  = $clog2(ROWS + 1);
  localparam int TOK_LEN = ROWS + COLS + 1;

  state_t              state_reg, state_next;
  logic [WCNT_W-1:0]   wcnt_reg, wcnt_next;
  logic [CNT_W-1:0]    vcnt_reg, vcnt_next;
  logic [CNT_W-1:0]    num_vec_reg, num_vec_next;
  logic [TOK_LEN-1:0]  tok_reg;
  logic [ROWS-1:0]     skew_busy;
  logic [ROWS*BIT_WIDTH-1:0] skew_q;
  logic                wt_fire;
  logic                in_fire;

  assign wt_fire = bus.wt_valid & (state_reg == ST_LOAD);
  assign in_fire = bus.in_valid & (state_reg == ST_FEED);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      wcnt_reg    <= '0;
      vcnt_reg    <= '0;
      num_vec_reg <= '0;
      tok_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      wcnt_reg    <= wcnt_next;
      vcnt_reg    <= vcnt_next;
      num_vec_reg <= num_vec_next;
      tok_reg     <= {tok_reg[TOK_LEN-2:0], in_fire};
    end
  end

  always_comb begin
    state_next   = state_reg;
    wcnt_next    = wcnt_reg;
    vcnt_next    = vcnt_reg;
    num_vec_next = num_vec_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          num_vec_next = bus.cfg_num_vec;
          wcnt_next    = '0;
          vcnt_next    = '0;
          state_next   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (wt_fire) begin
          if (wcnt_reg == WCNT_W'(ROWS - 1)) begin
            wcnt_next  = '0;
            state_next = (num_vec_reg == '0) ? ST_DRAIN : ST_FEED;
          end else begin
            wcnt_next = wcnt_reg + WCNT_W'(1);
          end
        end
      end
      ST_FEED: begin
        if (in_fire) begin
          if (vcnt_reg == num_vec_reg - CNT_W'(1)) begin
            vcnt_next  = '0;
            state_next = ST_DRAIN;
          end else begin
            vcnt_next = vcnt_reg + CNT_W'(1);
          end
        end
      end
      // Last result has left the array once no token or skewed element remains.
      ST_DRAIN: if (tok_reg == '0 && skew_busy == '0) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_skew
      logic [BIT_WIDTH-1:0] elem;
      assign elem = in_fire ? bus.in_data[gi*BIT_WIDTH +: BIT_WIDTH] : '0;
      skew_line #(.DEPTH(gi + 1), .WIDTH(BIT_WIDTH)) u_skew (
        .clk     (clk),
        .reset   (reset),
        .d       (elem),
        .q       (skew_q[gi*BIT_WIDTH +: BIT_WIDTH]),
        .nonzero (skew_busy[gi])
      );
    end
  endgenerate

  assign bus.busy          = (state_reg == ST_LOAD) || (state_reg == ST_FEED) ||
                             (state_reg == ST_DRAIN);
  assign bus.done          = (state_reg == ST_DONE);
  assign bus.wt_ready      = (state_reg == ST_LOAD);
  assign bus.in_ready      = (state_reg == ST_FEED);
  assign bus.arr_control   = wt_fire ? READ_WEIGHT_DATA : ~READ_WEIGHT_DATA;
  assign bus.arr_weight    = wt_fire ? bus.wt_data : '0;
  assign bus.arr_data      = skew_q;
  assign bus.arr_acc_top   = '0;
  assign bus.out_col_valid = tok_reg[TOK_LEN-1:ROWS+1];
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl with a behavioural 4x4 MAC array
// attached to the array-facing outputs to produce bottom-row results.
module tb_systolic_array_ctrl;
  localparam int ROWS = 4, COLS = 4, BW = 8, CNT_W = 8;
  localparam int AW = 2 * BW + ROWS - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  systolic_array_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .BIT_WIDTH(BW), .CNT_W(CNT_W)) bus();
  systolic_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .BIT_WIDTH(BW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  int s_cyc = 0;

  // Weight-stationary MAC array: weights shift down on control, features
  // hop right through a register per tile, accumulators flow down.
  int w_m [ROWS][COLS];
  int f_m [ROWS][COLS];
  int a_m [ROWS][COLS];
  always @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (bus.arr_control) begin
          if (r == 0) w_m[r][c] <= int'(bus.arr_weight[c*BW +: BW]);
          else        w_m[r][c] <= w_m[r-1][c];
        end
        if (c == 0) f_m[r][c] <= int'(bus.arr_data[r*BW +: BW]);
        else        f_m[r][c] <= f_m[r][c-1];
        if (r == 0) a_m[r][c] <= int'(bus.arr_acc_top[c*AW +: AW]) + w_m[r][c] * f_m[r][c];
        else        a_m[r][c] <= a_m[r-1][c] + w_m[r][c] * f_m[r][c];
      end
    end
  end

  int ctrl_cnt, ir_cnt, busy_cnt, done_cnt, done_cyc, ocv_cnt;
  int res_n [COLS];
  int res_v [COLS][8];
  int res_c [COLS][8];

  initial forever begin
    @(negedge clk);
    #1;
    if (bus.arr_control) ctrl_cnt++;
    if (bus.in_ready) ir_cnt++;
    if (bus.busy) busy_cnt++;
    if (bus.done) begin done_cnt++; done_cyc = cyc; end
    for (int c = 0; c < COLS; c++) begin
      if (bus.out_col_valid[c]) begin
        if (res_n[c] < 8) begin
          res_v[c][res_n[c]] = a_m[ROWS-1][c];
          res_c[c][res_n[c]] = cyc;
        end
        res_n[c]++;
        ocv_cnt++;
      end
    end
  end

  int wm [ROWS][COLS];
  logic [ROWS*BW-1:0] vecs [8];
  bit vv [8];

  function automatic logic [ROWS*BW-1:0] pk(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic clear_mon();
    ctrl_cnt = 0; ir_cnt = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1; ocv_cnt = 0;
    for (int c = 0; c < COLS; c++) res_n[c] = 0;
  endtask

  // mode 0: identity, 1: all ones, 2: even columns r+1, odd columns 1
  task automatic set_wm(input int mode);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        wm[r][c] = (mode == 0) ? ((r == c) ? 1 : 0) : (mode == 1) ? 1 : (c % 2 == 1) ? 1 : r + 1;
  endtask

  task automatic start_job(input int n);
    logic [CNT_W-1:0] nv;
    nv = n[CNT_W-1:0];
    @(negedge clk);
    bus.start = 1'b1;
    bus.cfg_num_vec = nv;
    s_cyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Beat k carries matrix row ROWS-1-k so it settles in that row.
  task automatic load_w(input bit stall);
    for (int k = 0; k < ROWS; k++) begin
      bus.wt_valid = 1'b1;
      for (int c = 0; c < COLS; c++) bus.wt_data[c*BW +: BW] = wm[ROWS-1-k][c][BW-1:0];
      @(negedge clk);
      if (stall && k < ROWS - 1) begin
        bus.wt_valid = 1'b0;
        bus.wt_data = '1;
        @(negedge clk);
      end
    end
    bus.wt_valid = 1'b0;
    bus.wt_data = '0;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = vv[i];
      bus.in_data = vv[i] ? vecs[i] : '1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data = '0;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.cfg_num_vec = 8'd3;
    bus.wt_valid = 1'b1; bus.wt_data = '1;
    bus.in_valid = 1'b1; bus.in_data = '1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.wt_ready !== 1'b0) begin n_bad++; $display("FAIL reset_wt_ready: got %b want 0", bus.wt_ready); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.arr_control !== 1'b0) begin n_bad++; $display("FAIL reset_arr_control: got %b want 0", bus.arr_control); end
    n_cmp++; if (bus.arr_weight !== '0) begin n_bad++; $display("FAIL reset_arr_weight: got %h want 0", bus.arr_weight); end
    n_cmp++; if (bus.arr_data !== '0) begin n_bad++; $display("FAIL reset_arr_data: got %h want 0", bus.arr_data); end
    n_cmp++; if (bus.out_col_valid !== '0) begin n_bad++; $display("FAIL reset_out_col_valid: got %b want 0", bus.out_col_valid); end
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b0; bus.wt_valid = 1'b0; bus.wt_data = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    @(negedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy); end
    $display("reset: outputs held at zero under reset, idle after release");
  endtask

  task automatic test_identity();
    clear_mon();
    set_wm(0);
    vecs[0] = pk(1, 2, 3, 4); vv[0] = 1'b1;
    start_job(1);
    load_w(1'b0);
    feed(1);
    run_to(s_cyc + 20);
    n_cmp++; if (ctrl_cnt != 4) begin n_bad++; $display("FAIL ident_ctrl_pulses: got %0d want 4", ctrl_cnt); end
    n_cmp++; if (busy_cnt != 15) begin n_bad++; $display("FAIL ident_busy_cycles: got %0d want 15", busy_cnt); end
    n_cmp++; if (ir_cnt != 1) begin n_bad++; $display("FAIL ident_in_ready_cycles: got %0d want 1", ir_cnt); end
    n_cmp++; if (done_cnt != 1 || done_cyc != s_cyc + 16) begin n_bad++; $display("FAIL ident_done: got %0d pulses at %0d want 1 at %0d", done_cnt, done_cyc, s_cyc + 16); end
    for (int c = 0; c < COLS; c++) begin
      n_cmp++;
      if (res_n[c] != 1 || res_v[c][0] != c + 1 || res_c[c][0] != s_cyc + 11 + c) begin
        n_bad++;
        $display("FAIL ident_col%0d: got n=%0d val=%0d cyc=%0d want n=1 val=%0d cyc=%0d", c, res_n[c], res_v[c][0], res_c[c][0] - s_cyc, c + 1, 11 + c);
      end
    end
    $display("identity: job of 1 vector, done at start+%0d", done_cyc - s_cyc);
  endtask

  task automatic test_back_to_back();
    int exp_v [3];
    exp_v = '{4, 2, 5};
    clear_mon();
    set_wm(1);
    vecs[0] = pk(1, 1, 1, 1); vecs[1] = pk(2, 0, 0, 0); vecs[2] = pk(0, 0, 0, 5);
    vv[0] = 1'b1; vv[1] = 1'b1; vv[2] = 1'b1;
    start_job(3);
    load_w(1'b0);
    feed(3);
    run_to(s_cyc + 24);
    n_cmp++; if (ocv_cnt != 12) begin n_bad++; $display("FAIL b2b_valid_count: got %0d want 12", ocv_cnt); end
    n_cmp++; if (ir_cnt != 3) begin n_bad++; $display("FAIL b2b_in_ready_cycles: got %0d want 3", ir_cnt); end
    n_cmp++; if (done_cnt != 1 || done_cyc != s_cyc + 18) begin n_bad++; $display("FAIL b2b_done: got %0d pulses at %0d want 1 at %0d", done_cnt, done_cyc, s_cyc + 18); end
    for (int c = 0; c < COLS; c++) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (res_n[c] != 3 || res_v[c][i] != exp_v[i] || res_c[c][i] != s_cyc + 11 + c + i) begin
          n_bad++;
          $display("FAIL b2b_col%0d_v%0d: got n=%0d val=%0d cyc=%0d want n=3 val=%0d cyc=%0d", c, i, res_n[c], res_v[c][i], res_c[c][i] - s_cyc, exp_v[i], 11 + c + i);
        end
      end
    end
    $display("back_to_back: 3 vectors, %0d valid beats", ocv_cnt);
  endtask

  task automatic test_stalls();
    clear_mon();
    set_wm(2);
    vecs[0] = pk(1, 2, 3, 4); vecs[1] = '0; vecs[2] = pk(1, 0, 0, 1);
    vv[0] = 1'b1; vv[1] = 1'b0; vv[2] = 1'b1;
    start_job(2);
    load_w(1'b1);
    feed(3);
    run_to(s_cyc + 26);
    n_cmp++; if (ctrl_cnt != 4) begin n_bad++; $display("FAIL stall_ctrl_pulses: got %0d want 4", ctrl_cnt); end
    n_cmp++; if (ocv_cnt != 8) begin n_bad++; $display("FAIL stall_valid_count: got %0d want 8", ocv_cnt); end
    n_cmp++; if (ir_cnt != 3) begin n_bad++; $display("FAIL stall_in_ready_cycles: got %0d want 3", ir_cnt); end
    n_cmp++; if (busy_cnt != 20) begin n_bad++; $display("FAIL stall_busy_cycles: got %0d want 20", busy_cnt); end
    n_cmp++; if (done_cnt != 1 || done_cyc != s_cyc + 21) begin n_bad++; $display("FAIL stall_done: got %0d pulses at %0d want 1 at %0d", done_cnt, done_cyc, s_cyc + 21); end
    for (int c = 0; c < COLS; c++) begin
      n_cmp++;
      if (res_n[c] != 2 || res_v[c][0] != ((c % 2 == 1) ? 10 : 30) || res_v[c][1] != ((c % 2 == 1) ? 2 : 5) ||
          res_c[c][0] != s_cyc + 14 + c || res_c[c][1] != s_cyc + 16 + c) begin
        n_bad++;
        $display("FAIL stall_col%0d: got n=%0d vals=%0d,%0d cyc=%0d,%0d want n=2 vals=%0d,%0d cyc=%0d,%0d", c, res_n[c],
                 res_v[c][0], res_v[c][1], res_c[c][0] - s_cyc, res_c[c][1] - s_cyc,
                 (c % 2 == 1) ? 10 : 30, (c % 2 == 1) ? 2 : 5, 14 + c, 16 + c);
      end
    end
    $display("stalls: weight gaps and feature bubble, done at start+%0d", done_cyc - s_cyc);
  endtask

  task automatic test_zero_vec();
    clear_mon();
    set_wm(1);
    start_job(0);
    bus.in_valid = 1'b1;
    bus.in_data = pk(9, 9, 9, 9);
    load_w(1'b0);
    run_to(s_cyc + 12);
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    n_cmp++; if (ctrl_cnt != 4) begin n_bad++; $display("FAIL zero_ctrl_pulses: got %0d want 4", ctrl_cnt); end
    n_cmp++; if (ir_cnt != 0) begin n_bad++; $display("FAIL zero_in_ready_cycles: got %0d want 0", ir_cnt); end
    n_cmp++; if (ocv_cnt != 0) begin n_bad++; $display("FAIL zero_valid_count: got %0d want 0", ocv_cnt); end
    n_cmp++; if (done_cnt != 1 || done_cyc != s_cyc + 6) begin n_bad++; $display("FAIL zero_done: got %0d pulses at %0d want 1 at %0d", done_cnt, done_cyc, s_cyc + 6); end
    $display("zero_vec: load only, done at start+%0d", done_cyc - s_cyc);
  endtask

  task automatic test_reset_mid_feed();
    clear_mon();
    set_wm(1);
    for (int i = 0; i < 4; i++) begin vecs[i] = pk(1, 1, 1, 1); vv[i] = 1'b1; end
    start_job(4);
    load_w(1'b0);
    feed(2);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.arr_data !== '0) begin n_bad++; $display("FAIL midrst_arr_data: got %h want 0", bus.arr_data); end
    n_cmp++; if (bus.out_col_valid !== '0) begin n_bad++; $display("FAIL midrst_out_col_valid: got %b want 0", bus.out_col_valid); end
    run_to(s_cyc + 30);
    n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt); end
    n_cmp++; if (ocv_cnt != 0) begin n_bad++; $display("FAIL midrst_no_valid: got %0d want 0", ocv_cnt); end
    clear_mon();
    vecs[0] = pk(1, 2, 3, 4); vv[0] = 1'b1;
    start_job(1);
    load_w(1'b0);
    feed(1);
    run_to(s_cyc + 20);
    n_cmp++; if (done_cnt != 1 || done_cyc != s_cyc + 16) begin n_bad++; $display("FAIL midrst_rerun_done: got %0d pulses at %0d want 1 at %0d", done_cnt, done_cyc, s_cyc + 16); end
    for (int c = 0; c < COLS; c++) begin
      n_cmp++;
      if (res_n[c] != 1 || res_v[c][0] != 10) begin
        n_bad++;
        $display("FAIL midrst_rerun_col%0d: got n=%0d val=%0d want n=1 val=10", c, res_n[c], res_v[c][0]);
      end
    end
    $display("reset_mid_feed: aborted job silent, rerun completed");
  endtask

  task automatic test_start_ignored();
    clear_mon();
    set_wm(1);
    vecs[0] = pk(1, 0, 0, 0); vecs[1] = pk(0, 2, 0, 0);
    vecs[2] = pk(3, 3, 3, 3); vecs[3] = pk(3, 3, 3, 3);
    for (int i = 0; i < 4; i++) vv[i] = 1'b1;
    start_job(2);
    bus.start = 1'b1;
    bus.cfg_num_vec = 8'd5;
    load_w(1'b0);
    feed(4);
    bus.start = 1'b0;
    run_to(s_cyc + 17);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ign_done_start_busy: got %b want 0", bus.busy); end
    run_to(s_cyc + 26);
    n_cmp++; if (ir_cnt != 2) begin n_bad++; $display("FAIL ign_in_ready_cycles: got %0d want 2", ir_cnt); end
    n_cmp++; if (busy_cnt != 16) begin n_bad++; $display("FAIL ign_busy_cycles: got %0d want 16", busy_cnt); end
    n_cmp++; if (done_cnt != 1 || done_cyc != s_cyc + 17) begin n_bad++; $display("FAIL ign_done: got %0d pulses at %0d want 1 at %0d", done_cnt, done_cyc, s_cyc + 17); end
    for (int c = 0; c < COLS; c++) begin
      n_cmp++;
      if (res_n[c] != 2 || res_v[c][0] != 1 || res_v[c][1] != 2) begin
        n_bad++;
        $display("FAIL ign_col%0d: got n=%0d vals=%0d,%0d want n=2 vals=1,2", c, res_n[c], res_v[c][0], res_v[c][1]);
      end
    end
    $display("start_ignored: busy/done-cycle starts and cfg change had no effect");
  endtask

  initial begin
    bus.start = 1'b0; bus.cfg_num_vec = '0;
    bus.wt_valid = 1'b0; bus.wt_data = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    clear_mon();
    test_reset();
    test_identity();
    test_back_to_back();
    test_stalls();
    test_zero_vec();
    test_reset_mid_feed();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
